keypad_scanner: RTL and testbench

- Scans the 4x4 matrix keypad on the top-level row_in/col_out pins, debounces the result and produces one key event per physical press.
- Each event is held on a valid/ready interface until the CPU's memory-mapped IO consumer takes it.
- Sits between the keypad pins and the IO bus; it is the upstream source of every keypad value the CPU reads.

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/keypad_col_driver.sv | 41 ++++
 rtl/keypad_scanner.sv | 162 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad IO definitions: debounce states, matrix geometry
// and the key-index-to-symbol table used by software-facing decode.
package keypad_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } kp_state_e;

  localparam logic [7:0] KEY_SYM [16] = '{
    8'h31, 8'h32, 8'h33, 8'h41,
    8'h34, 8'h35, 8'h36, 8'h42,
    8'h37, 8'h38, 8'h39, 8'h43,
    8'h2A, 8'h30, 8'h23, 8'h44
  };

  function automatic logic [7:0] key_sym(input logic [3:0] idx);
    return KEY_SYM[idx];
  endfunction

endpackage

// File: rtl/keypad_col_driver.sv
// Column scan timing: dwell counter, one-hot-low column rotation,
// per-column sample strobe and end-of-scan strobe.
module keypad_col_driver
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] col_o,
  output logic [1:0] col_idx_o,
  output logic       sample_o,
  output logic       scan_done_o
);

  localparam int DW = $clog2(SCAN_CYCLES);
  localparam logic [DW-1:0] LAST = DW'(SCAN_CYCLES - 1);

  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_q, col_d;

  always_comb begin
    sample_o    = (dwell_q == LAST);
    dwell_d     = sample_o ? '0 : dwell_q + 1'b1;
    col_d       = sample_o ? col_q + 2'd1 : col_q;
    scan_done_o = sample_o && (col_q == 2'd3);
    col_o       = ~(4'b0001 << col_q);
    col_idx_o   = col_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q <= '0;
      col_q   <= '0;
    end else begin
      dwell_q <= dwell_d;
      col_q   <= col_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row sync, per-scan priority hit, debounce FSM
// and a single-entry valid/ready event register with sticky overflow.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES    = 10000,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic       key_down,
  output logic       overflow
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [3:0] rs1_q, rs2_q;
  logic [1:0] col_idx;
  logic       sample, scan_done;

  keypad_col_driver #(
    .SCAN_CYCLES(SCAN_CYCLES)
  ) u_cols (
    .clk        (clk),
    .rst_n      (rst_n),
    .col_o      (col_out),
    .col_idx_o  (col_idx),
    .sample_o   (sample),
    .scan_done_o(scan_done)
  );

  logic       cur_hit;
  logic [1:0] cur_row;
  logic [3:0] cur_code;
  logic       hit_q;
  logic [3:0] code_q;
  logic       scan_hit;
  logic [3:0] scan_code;

  always_comb begin
    cur_hit = ~&rs2_q;
    cur_row = '0;
    for (int r = 3; r >= 0; r--) begin
      if (!rs2_q[r]) cur_row = 2'(r);
    end
    cur_code  = {cur_row, col_idx};
    scan_hit  = hit_q || cur_hit;
    scan_code = hit_q ? code_q : cur_code;
  end

  kp_state_e   state_q, state_d;
  logic [3:0]  cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic        emit;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    if (scan_done) begin
      unique case (state_q)
        IDLE: if (scan_hit) begin
          cand_d = scan_code;
          cnt_d  = CNT_ONE;
          if (DEBOUNCE_SCANS == 1) begin
            state_d = PRESSED;
            emit    = 1'b1;
          end else begin
            state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: if (!scan_hit) begin
          state_d = IDLE;
        end else if (scan_code != cand_q) begin
          cand_d = scan_code;
          cnt_d  = CNT_ONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            state_d = PRESSED;
            emit    = 1'b1;
          end
        end
        PRESSED: if (!scan_hit) begin
          cnt_d   = CNT_ONE;
          state_d = (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE;
        end
        RELEASE: if (scan_hit) begin
          state_d = PRESSED;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  logic       valid_q, valid_d;
  logic [3:0] kcode_q, kcode_d;
  logic       ovf_q, ovf_d;

  // A pending event is never overwritten unless it is taken this cycle
  always_comb begin
    valid_d = valid_q;
    kcode_d = kcode_q;
    ovf_d   = ovf_q;
    if (emit) begin
      if (!valid_q || key_ready) begin
        valid_d = 1'b1;
        kcode_d = scan_code;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && key_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q   <= 4'hF;
      rs2_q   <= 4'hF;
      hit_q   <= 1'b0;
      code_q  <= '0;
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      kcode_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      rs1_q   <= row_in;
      rs2_q   <= rs1_q;
      if (sample && (col_idx == 2'd0 || !hit_q)) begin
        hit_q  <= cur_hit;
        code_q <= cur_code;
      end
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      kcode_q <= kcode_d;
      ovf_q   <= ovf_d;
    end
  end

  assign key_valid = valid_q;
  assign key_code  = kcode_q;
  assign overflow  = ovf_q;
  assign key_down  = (state_q == PRESSED) || (state_q == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: matrix row model driven
// from col_out, expected key events queued and checked on arrival.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready = 1'b0;
  logic       key_down;
  logic       overflow;

  logic       static_en = 1'b1;
  logic [3:0] static_rows = 4'b1110;
  logic       press_en = 1'b0;
  logic [1:0] pr = '0;
  logic [1:0] pc = '0;

  always #5 clk = ~clk;

  assign row_in = static_en ? static_rows :
                  ((press_en && !col_out[pc]) ? ~(4'b0001 << pr) : 4'hF);

  keypad_scanner #(
    .SCAN_CYCLES   (4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ready(key_ready),
    .key_down (key_down),
    .overflow (overflow)
  );

  int         n_chk = 0;
  int         n_pass = 0;
  int         ev_cnt = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic pv = 1'b0;
  logic prd = 1'b0;

  // New event: valid now, and either idle or taken at the last edge
  always @(negedge clk) begin
    if (rst_n && key_valid && (!pv || prd)) begin
      ev_cnt++;
      if (exp_q.size() == 0) chk("unexp_evt", exp_q.size(), 1);
      else chk("evt_code", key_code, exp_q.pop_front());
    end
    pv  = key_valid;
    prd = key_ready;
  end

  task automatic wait_col(input logic [3:0] c);
    int t;
    t = 0;
    @(negedge clk);
    while (col_out !== c && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("col_wait", col_out, c);
  endtask

  task automatic align();
    wait_col(4'b0111);
    wait_col(4'b1110);
  endtask

  task automatic scans(input int n);
    repeat (n * 16) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #2 key_ready = v;
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c,
                       input bit expect_evt);
    align();
    pr = r;
    pc = c;
    press_en = 1'b1;
    if (expect_evt) exp_q.push_back({r, c});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_col", col_out, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_down", key_down, 0);
    chk("rst_ovf", overflow, 0);

    key_ready = 1'b1;
    exp_q.push_back(4'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("col_hold", col_out, 4'b1110);
    @(negedge clk);
    chk("col_rot", col_out, 4'b1101);
    repeat (27) @(negedge clk);
    chk("lat_pre", key_valid, 0);
    @(negedge clk);
    chk("lat_evt", key_valid, 1);
    chk("lat_code", key_code, 0);
    scans(10);
    chk("no_repeat", ev_cnt, 1);
    chk("held_down", key_down, 1);
    static_rows = 4'hF;
    scans(3);
    chk("idle_down", key_down, 0);
    static_en = 1'b0;

    press(2'd2, 2'd2, 1'b1);
    scans(4);
    chk("m10_down", key_down, 1);
    press_en = 1'b0;
    scans(3);
    chk("m10_up", key_down, 0);
    press(2'd3, 2'd1, 1'b1);
    scans(4);
    press_en = 1'b0;
    scans(3);
    chk("matrix_evts", ev_cnt, 3);

    align();
    pr = 2'd0;
    pc = 2'd0;
    for (int i = 0; i < 8; i++) begin
      press_en = (i % 2 == 0);
      scans(1);
      chk("bounce_down", key_down, 0);
    end
    press_en = 1'b0;
    scans(2);
    chk("bounce_evts", ev_cnt, 3);

    set_ready(1'b0);
    press(2'd0, 2'd0, 1'b1);
    scans(4);
    press_en = 1'b0;
    scans(3);
    press(2'd2, 2'd2, 1'b0);
    scans(4);
    chk("ovf_valid", key_valid, 1);
    chk("ovf_code", key_code, 0);
    chk("ovf_flag", overflow, 1);
    press_en = 1'b0;
    scans(3);
    set_ready(1'b1);
    set_ready(1'b0);
    @(negedge clk);
    chk("ack_clear", key_valid, 0);

    press(2'd1, 2'd1, 1'b1);
    scans(4);
    press_en = 1'b0;
    scans(3);
    chk("pend_valid", key_valid, 1);
    chk("pend_code", key_code, 5);
    press(2'd1, 2'd3, 1'b1);
    wait_col(4'b0111);
    wait_col(4'b1110);
    wait_col(4'b0111);
    repeat (3) @(posedge clk);
    #2 key_ready = 1'b1;
    @(posedge clk);
    #2 key_ready = 1'b0;
    @(negedge clk);
    chk("same_valid", key_valid, 1);
    chk("same_code", key_code, 7);
    press_en = 1'b0;
    scans(3);
    chk("ovf_sticky", overflow, 1);

    set_ready(1'b1);
    press(2'd1, 2'd1, 1'b0);
    wait_col(4'b0111);
    wait_col(4'b1110);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_valid", key_valid, 0);
    chk("mid_down", key_down, 0);
    chk("mid_ovf", overflow, 0);
    exp_q.push_back(4'd5);
    rst_n = 1'b1;
    repeat (31) @(negedge clk);
    chk("mid_pre", key_valid, 0);
    @(negedge clk);
    chk("mid_evt", key_valid, 1);
    press_en = 1'b0;
    scans(3);
    chk("sb_empty", exp_q.size(), 0);
    chk("total_evts", ev_cnt, 7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
